// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - program counter with next-PC select, stall hold and return-address stack
// Optional: define PC_ALIGN_CHECK_EN to trap misaligned jump-register targets to EXC_VEC.
module pc_unit_ras #(
    parameter int              ADDR_W    = 32,
    parameter int              OFFSET_W  = 16,
    parameter int              INDEX_W   = 26,
    parameter logic [31:0]     RESET_VEC = 32'h0000_3000,
    parameter logic [31:0]     EXC_VEC   = 32'h0000_4180,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         PcReSet_n,
    input  logic                         Stall,
    input  logic                         Exc,
    input  logic                         BrTaken,
    input  logic [OFFSET_W-1:0]          Offset,
    input  logic                         Jump,
    input  logic [INDEX_W-1:0]           Index,
    input  logic                         Jr,
    input  logic [ADDR_W-1:0]            JrTarget,
    input  logic                         Link,
    input  logic                         Ret,
    output logic [ADDR_W-1:0]            PC,
    output logic [ADDR_W-1:0]            PcPlus4,
    output logic [ADDR_W-1:0]            RasTop,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasHit,
    output logic                         AlignErr
);

    localparam int                PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_hit;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_jmp_target;
    logic [ADDR_W-1:0] w_jr_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_top;
    logic [PTR_W-1:0]  w_push_ptr;
    logic              w_empty;

    assign w_pc_plus4   = r_pc + ADDR_W'(4);
    assign w_br_target  = w_pc_plus4 + {{(ADDR_W-OFFSET_W-2){Offset[OFFSET_W-1]}}, Offset, 2'b00};
    assign w_jmp_target = {w_pc_plus4[ADDR_W-1:INDEX_W+2], Index, 2'b00};
    assign w_empty      = (r_count == '0);
    assign w_top        = r_ras[r_top_ptr];
    assign w_push_ptr   = r_top_ptr + PTR_W'(1);

`ifdef PC_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_align_err;

    assign w_misalign  = Jr && (JrTarget[1:0] != 2'b00);
    assign w_jr_target = w_misalign ? EXC_VEC : JrTarget;

    always_ff @(posedge Clk or negedge PcReSet_n) begin
        if (!PcReSet_n) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= !Exc && !Stall && w_misalign;
        end
    end

    assign AlignErr = r_align_err;
`else
    assign w_jr_target = JrTarget;
    assign AlignErr    = 1'b0;
`endif

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (Jr)           w_next_pc = w_jr_target;
        else if (Jump)    w_next_pc = w_jmp_target;
        else if (BrTaken) w_next_pc = w_br_target;
    end

    // The stack is circular: pushing when full overwrites the oldest slot, which is the one after the top.
    always_ff @(posedge Clk or negedge PcReSet_n) begin
        if (!PcReSet_n) begin
            r_pc      <= RESET_VEC;
            r_top_ptr <= '0;
            r_count   <= '0;
            r_hit     <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
        end else if (Exc) begin
            r_pc  <= EXC_VEC;
            r_hit <= 1'b0;
        end else if (!Stall) begin
            r_pc  <= w_next_pc;
            r_hit <= Ret && !w_empty && (w_top == JrTarget);
            if (Link && (!Ret || w_empty)) begin
                r_top_ptr          <= w_push_ptr;
                r_ras[w_push_ptr]  <= w_pc_plus4;
                if (r_count != FULL) r_count <= r_count + 1'b1;
            end else if (Link && Ret) begin
                r_ras[r_top_ptr] <= w_pc_plus4;
            end else if (Ret && !w_empty) begin
                r_top_ptr <= r_top_ptr - PTR_W'(1);
                r_count   <= r_count - 1'b1;
            end
        end
    end

    assign PC       = r_pc;
    assign PcPlus4  = w_pc_plus4;
    assign RasTop   = w_empty ? '0 : w_top;
    assign RasCount = r_count;
    assign RasHit   = r_hit;

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed self-checking bench for pc_unit_ras
module tb_pc_unit_ras;

    logic        Clk;
    logic        PcReSet_n;
    logic        Stall, Exc, BrTaken, Jump, Jr, Link, Ret;
    logic [15:0] Offset;
    logic [25:0] Index;
    logic [31:0] JrTarget;
    logic [31:0] PC, PcPlus4, RasTop;
    logic [2:0]  RasCount;
    logic        RasHit, AlignErr;

    int errors = 0;
    int checks = 0;

    pc_unit_ras dut (
        .Clk(Clk), .PcReSet_n(PcReSet_n), .Stall(Stall), .Exc(Exc),
        .BrTaken(BrTaken), .Offset(Offset), .Jump(Jump), .Index(Index),
        .Jr(Jr), .JrTarget(JrTarget), .Link(Link), .Ret(Ret),
        .PC(PC), .PcPlus4(PcPlus4), .RasTop(RasTop), .RasCount(RasCount),
        .RasHit(RasHit), .AlignErr(AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        Stall = 0; Exc = 0; BrTaken = 0; Jump = 0; Jr = 0; Link = 0; Ret = 0;
        Offset = '0; Index = '0; JrTarget = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        idle_inputs();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        idle_inputs();
        Jr = 1; JrTarget = target;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        PcReSet_n = 0;
        #12;
        checks++; if (PC !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h3000); end
        checks++; if (PcPlus4 !== 32'h3004) begin errors++; $display("FAIL reset_pcplus4: got %h want %h", PcPlus4, 32'h3004); end
        checks++; if (RasCount !== 3'd0 || RasTop !== 32'h0) begin errors++; $display("FAIL reset_ras: got cnt=%0d top=%h want 0/0", RasCount, RasTop); end
        checks++; if (RasHit !== 1'b0 || AlignErr !== 1'b0) begin errors++; $display("FAIL reset_flags: got hit=%b aerr=%b want 0/0", RasHit, AlignErr); end
        @(negedge Clk);
        PcReSet_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008; exp_pc[3] = 32'h300C;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++; if (PC !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, exp_pc[i]); end
        end
    endtask

    task automatic test_branch();
        goto_pc(32'h3000);
        BrTaken = 1; Offset = 16'hFFFF;
        tick();
        checks++; if (PC !== 32'h3000) begin errors++; $display("FAIL branch_back: got %h want %h", PC, 32'h3000); end
        BrTaken = 1; Offset = 16'h0004;
        tick();
        checks++; if (PC !== 32'h3014) begin errors++; $display("FAIL branch_fwd: got %h want %h", PC, 32'h3014); end
    endtask

    task automatic test_jump();
        goto_pc(32'h3010);
        Jump = 1; Index = 26'h0000C40;
        tick();
        checks++; if (PC !== 32'h0000_3100) begin errors++; $display("FAIL jump: got %h want %h", PC, 32'h3100); end
        goto_pc(32'h3010);
        Jump = 1; Index = 26'h0000C40; BrTaken = 1; Offset = 16'h0010; Jr = 1; JrTarget = 32'h5000;
        tick();
        checks++; if (PC !== 32'h5000) begin errors++; $display("FAIL jr_priority: got %h want %h", PC, 32'h5000); end
    endtask

    task automatic test_ras_push_pop();
        logic [31:0] ret_addr [4];
        ret_addr[0] = 32'h3044; ret_addr[1] = 32'h3034; ret_addr[2] = 32'h3024; ret_addr[3] = 32'h3014;
        for (int i = 0; i < 5; i++) begin
            goto_pc(32'h3000 + 32'(16 * i));
            Link = 1;
            tick();
            checks++; if (RasCount !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL push_cnt%0d: got %0d want %0d", i, RasCount, (i < 4) ? i + 1 : 4); end
        end
        checks++; if (RasTop !== 32'h3044) begin errors++; $display("FAIL push_top: got %h want %h", RasTop, 32'h3044); end
        for (int k = 0; k < 4; k++) begin
            Ret = 1; Jr = 1; JrTarget = ret_addr[k];
            tick();
            checks++; if (RasHit !== 1'b1 || RasCount !== 3'(3 - k)) begin errors++; $display("FAIL pop%0d: got hit=%b cnt=%0d want 1/%0d", k, RasHit, RasCount, 3 - k); end
            checks++; if (PC !== ret_addr[k]) begin errors++; $display("FAIL pop_pc%0d: got %h want %h", k, PC, ret_addr[k]); end
        end
        Ret = 1; Jr = 1; JrTarget = 32'h3004;
        tick();
        checks++; if (RasHit !== 1'b0 || RasCount !== 3'd0 || RasTop !== 32'h0) begin errors++; $display("FAIL pop_empty: got hit=%b cnt=%0d top=%h want 0/0/0", RasHit, RasCount, RasTop); end
    endtask

    task automatic test_ras_replace_miss();
        goto_pc(32'h3300);
        Link = 1;
        tick();
        Link = 1; Ret = 1; Jr = 1; JrTarget = 32'h3304;
        tick();
        checks++; if (RasHit !== 1'b1 || RasCount !== 3'd1 || RasTop !== 32'h3308) begin errors++; $display("FAIL replace: got hit=%b cnt=%0d top=%h want 1/1/3308", RasHit, RasCount, RasTop); end
        tick();
        checks++; if (RasHit !== 1'b0) begin errors++; $display("FAIL hit_pulse: got %b want 0", RasHit); end
        Ret = 1; Jr = 1; JrTarget = 32'h1234;
        tick();
        checks++; if (RasHit !== 1'b0 || RasCount !== 3'd0 || PC !== 32'h1234) begin errors++; $display("FAIL pop_miss: got hit=%b cnt=%0d pc=%h want 0/0/1234", RasHit, RasCount, PC); end
    endtask

    task automatic test_stall();
        goto_pc(32'h3200);
        Link = 1;
        tick();
        Stall = 1; BrTaken = 1; Offset = 16'h0004; Link = 1;
        tick();
        checks++; if (PC !== 32'h3204 || RasCount !== 3'd1 || RasTop !== 32'h3204) begin errors++; $display("FAIL stall_hold: got pc=%h cnt=%0d top=%h want 3204/1/3204", PC, RasCount, RasTop); end
        Stall = 1; Exc = 1; Link = 1;
        tick();
        checks++; if (PC !== 32'h4180 || RasCount !== 3'd1) begin errors++; $display("FAIL stall_exc: got pc=%h cnt=%0d want 4180/1", PC, RasCount); end
    endtask

    task automatic test_mid_reset();
        Link = 1; tick();
        Link = 1; tick();
        checks++; if (RasCount !== 3'd3 || RasTop !== 32'h4188) begin errors++; $display("FAIL pre_reset_ras: got cnt=%0d top=%h want 3/4188", RasCount, RasTop); end
        PcReSet_n = 0;
        #2;
        checks++; if (PC !== 32'h3000 || RasCount !== 3'd0 || RasTop !== 32'h0) begin errors++; $display("FAIL mid_reset: got pc=%h cnt=%0d top=%h want 3000/0/0", PC, RasCount, RasTop); end
        @(negedge Clk);
        PcReSet_n = 1;
        tick();
        checks++; if (PC !== 32'h3004) begin errors++; $display("FAIL post_reset: got %h want %h", PC, 32'h3004); end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc0, exp_pc1;
        logic        exp_err;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc0 = 32'h4180; exp_pc1 = 32'h4184; exp_err = 1'b1;
`else
        exp_pc0 = 32'h5002; exp_pc1 = 32'h5006; exp_err = 1'b0;
`endif
        Jr = 1; JrTarget = 32'h5002;
        tick();
        checks++; if (PC !== exp_pc0 || AlignErr !== exp_err) begin errors++; $display("FAIL align_jr: got pc=%h aerr=%b want %h/%b", PC, AlignErr, exp_pc0, exp_err); end
        tick();
        checks++; if (PC !== exp_pc1 || AlignErr !== 1'b0) begin errors++; $display("FAIL align_clear: got pc=%h aerr=%b want %h/0", PC, AlignErr, exp_pc1); end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        checks++; if (PcPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 0", PcPlus4); end
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", PC); end
    endtask

    initial begin
        idle_inputs();
        PcReSet_n = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_ras_push_pop();
        test_ras_replace_miss();
        test_stall();
        test_mid_reset();
        test_align();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
